// File: rtl/div_pkg.sv
// Shared opcode and FSM state encodings for the iterative RV32M divider.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration; the dividend is shifted out of q from its MSB.
// The partial remainder is always below the divisor, so 32 bits hold it; the compare uses 33.
module div_step (
  input  logic [31:0] rem_in,
  input  logic [31:0] q_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic [31:0] q_out
);

  logic [32:0] shifted;
  logic        ge;

  assign shifted = {rem_in, q_in[31]};
  assign ge      = shifted >= {1'b0, divisor};
  assign rem_out = ge ? (shifted[31:0] - divisor) : shifted[31:0];
  assign q_out   = {q_in[30:0], ge};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU; result o_valid 32/UNROLL+1 cycles after accept, held until i_ready.
// Optional `DIV_FAST_PATH_EN: divide-by-zero and signed overflow bypass the iterations (result next cycle).
module div_unit
  import div_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1_rdata,
  input  logic [31:0] i_rs2_rdata,
  input  logic [4:0]  i_rd_waddr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata
);

  localparam int N = 32 / UNROLL;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        is_rem, neg_q, neg_r;
  logic [31:0] dvs, rem, quo;

  logic [UNROLL:0][31:0] rem_c;
  logic [UNROLL:0][31:0] quo_c;

  logic        sgn, s1, s2;
  logic [31:0] mag1, mag2;
  logic [31:0] q_fix, r_fix, res;

  assign sgn  = (i_op == OP_DIV) || (i_op == OP_REM);
  assign s1   = sgn & i_rs1_rdata[31];
  assign s2   = sgn & i_rs2_rdata[31];
  assign mag1 = s1 ? -i_rs1_rdata : i_rs1_rdata;
  assign mag2 = s2 ? -i_rs2_rdata : i_rs2_rdata;

  assign rem_c[0] = rem;
  assign quo_c[0] = quo;

  generate
    for (genvar g = 0; g < UNROLL; g++) begin : g_step
      div_step u_step (
        .rem_in  (rem_c[g]),
        .q_in    (quo_c[g]),
        .divisor (dvs),
        .rem_out (rem_c[g+1]),
        .q_out   (quo_c[g+1])
      );
    end
  endgenerate

  // A zero divisor leaves the all-ones quotient positive whatever the dividend sign.
  assign q_fix = (neg_q && (dvs != '0)) ? -quo_c[UNROLL] : quo_c[UNROLL];
  assign r_fix = neg_r ? -rem_c[UNROLL] : rem_c[UNROLL];
  assign res   = is_rem ? r_fix : q_fix;

`ifdef DIV_FAST_PATH_EN
  logic        div_zero, ovf;
  logic [31:0] fast_res;

  assign div_zero = i_rs2_rdata == '0;
  assign ovf      = sgn && (i_rs1_rdata == 32'h8000_0000) && (i_rs2_rdata == 32'hFFFF_FFFF);
  assign fast_res = div_zero ? (i_op[1] ? i_rs1_rdata : 32'hFFFF_FFFF)
                             : (i_op[1] ? 32'h0 : 32'h8000_0000);
`endif

  assign o_ready  = state == S_IDLE;
  assign o_valid  = state == S_DONE;
  assign o_rd_wen = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      is_rem     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      dvs        <= '0;
      rem        <= '0;
      quo        <= '0;
      o_rd_waddr <= '0;
      o_rd_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            o_rd_waddr <= i_rd_waddr;
            is_rem     <= i_op[1];
            neg_q      <= s1 ^ s2;
            neg_r      <= s1;
            dvs        <= mag2;
            rem        <= '0;
            quo        <= mag1;
            cnt        <= 5'(N - 1);
            state      <= S_CALC;
`ifdef DIV_FAST_PATH_EN
            if (div_zero || ovf) begin
              o_rd_wdata <= fast_res;
              cnt        <= '0;
              state      <= S_DONE;
            end
`endif
          end
        end
        S_CALC: begin
          rem <= rem_c[UNROLL];
          quo <= quo_c[UNROLL];
          if (cnt == '0) begin
            o_rd_wdata <= res;
            state      <= S_DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_DONE: begin
          if (i_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit (UNROLL=1): results, latency, handshake hold and mid-run reset.
module tb_div_unit;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_ready;
  logic        o_ready, o_valid, o_rd_wen;
  logic [1:0]  i_op;
  logic [31:0] i_rs1_rdata, i_rs2_rdata, o_rd_wdata;
  logic [4:0]  i_rd_waddr, o_rd_waddr;

  always #5 i_clk = ~i_clk;

  div_unit #(.UNROLL(1)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
    .i_rs1_rdata (i_rs1_rdata),
    .i_rs2_rdata (i_rs2_rdata),
    .i_rd_waddr  (i_rd_waddr),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_rd_wen    (o_rd_wen),
    .o_rd_waddr  (o_rd_waddr),
    .o_rd_wdata  (o_rd_wdata)
  );

`ifdef DIV_FAST_PATH_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = 33;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the first negedge showing o_valid.
  task automatic issue(input vec_t v, output int lat);
    i_valid     = 1'b1;
    i_op        = v.op;
    i_rs1_rdata = v.a;
    i_rs2_rdata = v.b;
    i_rd_waddr  = v.rd;
    @(negedge i_clk);
    i_valid = 1'b0;
    lat     = 1;
    while (!o_valid && lat < 100) begin
      @(negedge i_clk);
      lat++;
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    int lat;
    chk($sformatf("%s ready", name), 32'(o_ready), 32'd1);
    issue(v, lat);
    chk($sformatf("%s latency", name), 32'(lat), 32'(v.fast ? FAST_LAT : 33));
    chk($sformatf("%s wdata", name), o_rd_wdata, v.exp);
    chk($sformatf("%s waddr", name), 32'(o_rd_waddr), 32'(v.rd));
    chk($sformatf("%s wen", name), 32'(o_rd_wen), 32'd1);
    chk($sformatf("%s busy", name), 32'(o_ready), 32'd0);
    @(negedge i_clk);
    chk($sformatf("%s wen_drop", name), 32'(o_rd_wen), 32'd0);
    chk($sformatf("%s idle", name), 32'(o_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    int   lat;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          5'd5,  32'd14,         1'b0};
    vecs[1]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD,  1'b0};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF,  1'b0};
    vecs[3]  = '{2'b11, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'd1,          1'b0};
    vecs[4]  = '{2'b00, 32'd5,          32'd0,          5'd4,  32'hFFFF_FFFF,  1'b1};
    vecs[5]  = '{2'b10, 32'd5,          32'd0,          5'd6,  32'd5,          1'b1};
    vecs[6]  = '{2'b00, 32'hFFFF_FFFB,  32'd0,          5'd7,  32'hFFFF_FFFF,  1'b1};
    vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,  1'b1};
    vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'd0,          1'b1};
    vecs[9]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          1'b0};
    vecs[10] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  5'd11, 32'hFFFF_FFFD,  1'b0};
    vecs[11] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd12, 32'd1,          1'b0};
    vecs[12] = '{2'b11, 32'hFFFF_FFFB,  32'd0,          5'd13, 32'hFFFF_FFFB,  1'b1};
    vecs[13] = '{2'b01, 32'd0,          32'd0,          5'd14, 32'hFFFF_FFFF,  1'b1};
    vecs[14] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          5'd15, 32'hFFFF_FFFF,  1'b0};
    vecs[15] = '{2'b01, 32'd10,         32'd3,          5'd0,  32'd3,          1'b0};

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_op = 2'b00;
    i_rs1_rdata = '0; i_rs2_rdata = '0; i_rd_waddr = '0;
    repeat (2) @(negedge i_clk);
    chk("reset ready", 32'(o_ready), 32'd1);
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset wen", 32'(o_rd_wen), 32'd0);
    chk("reset waddr", 32'(o_rd_waddr), 32'd0);
    chk("reset wdata", o_rd_wdata, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Consumer stalls in DONE for five cycles.
    v = '{2'b01, 32'd1000, 32'd10, 5'd7, 32'd100, 1'b0};
    i_ready = 1'b0;
    issue(v, lat);
    chk("hold latency", 32'(lat), 32'd33);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d valid", i), 32'(o_valid), 32'd1);
      chk($sformatf("hold%0d wdata", i), o_rd_wdata, 32'd100);
      chk($sformatf("hold%0d waddr", i), 32'(o_rd_waddr), 32'd7);
      chk($sformatf("hold%0d wen", i), 32'(o_rd_wen), 32'd0);
      chk($sformatf("hold%0d ready", i), 32'(o_ready), 32'd0);
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    #1;
    chk("hold release wen", 32'(o_rd_wen), 32'd1);
    @(negedge i_clk);
    chk("hold after wen", 32'(o_rd_wen), 32'd0);
    chk("hold after valid", 32'(o_valid), 32'd0);
    chk("hold after ready", 32'(o_ready), 32'd1);

    // Reset while iterating discards the in-flight result.
    i_valid = 1'b1; i_op = 2'b01; i_rs1_rdata = 32'd1000; i_rs2_rdata = 32'd10; i_rd_waddr = 5'd9;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    chk("calc busy", 32'(o_ready), 32'd0);
    chk("calc valid", 32'(o_valid), 32'd0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("midrst ready", 32'(o_ready), 32'd1);
    chk("midrst valid", 32'(o_valid), 32'd0);
    chk("midrst wen", 32'(o_rd_wen), 32'd0);
    chk("midrst waddr", 32'(o_rd_waddr), 32'd0);
    chk("midrst wdata", o_rd_wdata, 32'd0);
    v = '{2'b01, 32'd9, 32'd3, 5'd3, 32'd3, 1'b0};
    run_op(v, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
